// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. It generates the PC, drives a fixed-latency
// instruction-memory read port, tracks reads in flight, and buffers returned
// words so that decode can apply backpressure. Execute can redirect the PC,
// and a halt level stops new fetches.
//
// Parameters
//   RESET_PC   PC loaded on reset
//   MEM_LAT    instruction-memory read latency in cycles (1..4)
//   BUF_DEPTH  instruction buffer entries (power of 2, >= MEM_LAT+2)
//
// Ports
//   clk             clock, all state updates on posedge
//   rst_n           asynchronous active-low reset
//   imem_raddr      word address to instruction memory (pc[15:1])
//   imem_rdata      instruction word, valid MEM_LAT cycles after its address
//   halt            level; blocks new fetches while high
//   redirect_valid  single-cycle pulse that loads redirect_pc
//   redirect_pc     target PC (bit 0 ignored)
//   out_valid       buffer head holds a valid instruction
//   out_ready       decode accepts the head this cycle
//   out_instr       head instruction
//   out_pc          PC of the head instruction
//
// Handshake: the head transfers at the rising edge of any cycle in which
// out_valid && out_ready. out_valid never depends on out_ready, and while
// out_valid && !out_ready the head (out_instr/out_pc) holds steady.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          MEM_LAT   = 2,
    parameter int          BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [14:0] imem_raddr,
    input  logic [15:0] imem_rdata,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    // Program counter of the next fetch.
    logic [15:0] pc;

    // In-flight tracker: one stage per cycle of memory latency. The last
    // stage lines up with the cycle in which imem_rdata carries its word.
    logic [MEM_LAT-1:0] infl_valid;
    logic [15:0]        infl_pc [MEM_LAT];

    // Circular instruction buffer.
    logic [15:0]      buf_instr [BUF_DEPTH];
    logic [15:0]      buf_pc    [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occ;

    logic [CNT_W-1:0] infl_cnt;
    logic [CNT_W:0]   credit_used;
    logic             issue;
    logic             push;
    logic             pop;

    // Bit 0 of the redirect target is dropped; the word address is all that
    // matters.
    logic redirect_pc_lsb_unused;
    assign redirect_pc_lsb_unused = redirect_pc[0];

    // -----------------------------------------------------------------------
    // Credit accounting
    // -----------------------------------------------------------------------
    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            infl_cnt = infl_cnt + CNT_W'(infl_valid[i]);
        end
    end

    // Every in-flight read owns a buffer slot, so a returning word always
    // finds room. A pop in this cycle is deliberately not counted as a freed
    // slot; that keeps the issue decision off the out_ready path.
    assign credit_used = {1'b0, occ} + {1'b0, infl_cnt};
    assign issue       = !halt && !redirect_valid
                         && (credit_used < (CNT_W + 1)'(BUF_DEPTH));

    assign push = infl_valid[MEM_LAT-1];
    assign pop  = out_valid && out_ready;

    assign imem_raddr = pc[15:1];

    // -----------------------------------------------------------------------
    // PC register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[15:1], 1'b0};
        end else if (issue) begin
            pc <= pc + 16'd2;
        end
    end

    // -----------------------------------------------------------------------
    // In-flight shift register. Stage 0 takes issue directly, which is
    // already low in a redirect cycle; later stages are squashed on redirect
    // so stale words never reach the buffer.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_valid <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                infl_pc[i] <= '0;
            end
        end else begin
            infl_valid[0] <= issue;
            infl_pc[0]    <= pc;
            for (int i = 1; i < MEM_LAT; i++) begin
                infl_valid[i] <= infl_valid[i-1] && !redirect_valid;
                infl_pc[i]    <= infl_pc[i-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Buffer pointers and occupancy. Redirect empties the buffer outright;
    // a head that handshakes in that same cycle was still delivered.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Buffer storage needs no reset: entries are only visible while occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= infl_pc[MEM_LAT-1];
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: head of the buffer, forced to zero while empty so reset (which
    // clears occ asynchronously) drops everything immediately.
    // -----------------------------------------------------------------------
    assign out_valid = (occ != '0);
    assign out_instr = out_valid ? buf_instr[rd_ptr] : 16'h0000;
    assign out_pc    = out_valid ? buf_pc[rd_ptr]    : 16'h0000;

    // The credit rule makes this unreachable; reaching it means lost data.
    push_into_full : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && occ == CNT_W'(BUF_DEPTH))
    ) else $fatal(1, "fetch_unit: push into full instruction buffer");

endmodule
